// File: rtl/bit_serial_adder.sv
// bit_serial_adder: adds two WIDTH-bit operands plus carry-in one bit per clock, LSB first.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             BUSY,
  output logic             DONE
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, s_q, s_d;
  logic             c_q, c_d, cout_q, cout_d, sum_b;
  logic [CW-1:0]    cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    sum_b   = a_q[0] ^ b_q[0] ^ c_q;
    if (state_q == SHIFT) begin
      r_d   = WIDTH'({sum_b, r_q} >> 1);
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      c_d   = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
      cnt_d = cnt_q + 1'b1;
      // the result register is complete on this edge, so publish the next-state value
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = FINISH;
        s_d     = r_d;
        cout_d  = c_d;
      end
    end else if (START) begin
      state_d = SHIFT;
      a_d     = A;
      b_d     = B;
      c_d     = Cin;
      cnt_d   = '0;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end
  assign S    = s_q;
  assign Cout = cout_q;
  assign BUSY = (state_q == SHIFT);
  assign DONE = (state_q == FINISH);
endmodule
